hilo_div_sequencer: RTL and testbench

Multi-cycle divide controller for the MIPS32 execute stage. It sequences a radix-2 restoring divider for DIV/DIVU and stalls the pipeline while the divider iterates. It presents the quotient and remainder as a HI/LO write (HI = remainder, LO = quotient) on the same `writeHILO` encoding that the EX/MEM pipeline register carries. It sits beside the ALU and feeds the EX-stage HI/LO mux.

---
 rtl/cpu_defs_pkg.sv | 25 ++
 rtl/hilo_div_sequencer_div_step.sv | 33 +++
 rtl/hilo_div_sequencer.sv | 152 +++++++++++++++
 tb/tb_hilo_div_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// ============================================================================
// Module      : cpu_defs_pkg
// Description : Shared CPU definitions: divider state encoding, HI/LO write codes
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_defs_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE    = 2'd0,
        DIV_DIVZERO = 2'd1,
        DIV_RUN     = 2'd2,
        DIV_DONE    = 2'd3
    } div_state_t;

    // writeHILO encoding carried by the EX/MEM pipeline register
    localparam logic [1:0] HILO_NONE = 2'b00;
    localparam logic [1:0] HILO_LO   = 2'b01;
    localparam logic [1:0] HILO_HI   = 2'b10;
    localparam logic [1:0] HILO_BOTH = 2'b11;

endpackage

`default_nettype wire

// File: rtl/hilo_div_sequencer_div_step.sv
// ============================================================================
// Module      : div_step
// Description : One combinational radix-2 restoring divide iteration
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] quo_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] quo_o
);

    logic [DATA_W:0]   w_shift;
    logic              w_ge;
    logic [DATA_W-1:0] w_diff;

    // Shifted partial remainder needs one extra bit; when it is >= divisor the
    // true difference is below the divisor, so the low DATA_W bits are exact.
    assign w_shift = {rem_i, quo_i[DATA_W-1]};
    assign w_ge    = (w_shift >= {1'b0, divisor_i});
    assign w_diff  = w_shift[DATA_W-1:0] - divisor_i;

    assign rem_o = w_ge ? w_diff : w_shift[DATA_W-1:0];
    assign quo_o = {quo_i[DATA_W-2:0], w_ge};

endmodule

`default_nettype wire

// File: rtl/hilo_div_sequencer.sv
// ============================================================================
// Module      : hilo_div_sequencer
// Description : Multi-cycle DIV/DIVU controller producing a HI/LO write
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hilo_div_sequencer
    import cpu_defs_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    input  logic              annul_i,
    output logic              stall_o,
    output logic              ready_o,
    output logic [1:0]        writeHILO_o,
    output logic [DATA_W-1:0] HI_data_o,
    output logic [DATA_W-1:0] LO_data_o
);

    localparam int              CNT_W      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DATA_W - 1);

    div_state_t        r_state;
    div_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_dvs;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    logic              w_accept;
    logic              w_dvs_zero;
    logic              w_dvd_neg;
    logic              w_dvs_neg;
    logic [DATA_W-1:0] w_dvd_mag;
    logic [DATA_W-1:0] w_dvs_mag;
    logic [DATA_W-1:0] w_step_rem;
    logic [DATA_W-1:0] w_step_quo;
    logic [DATA_W-1:0] w_fix_q;
    logic [DATA_W-1:0] w_fix_r;
    logic              w_last;

    assign w_accept   = (r_state == DIV_IDLE) && start_i && !annul_i;
    assign w_dvs_zero = (divisor_i == '0);
    assign w_dvd_neg  = signed_i && dividend_i[DATA_W-1];
    assign w_dvs_neg  = signed_i && divisor_i[DATA_W-1];
    assign w_dvd_mag  = w_dvd_neg ? (-dividend_i) : dividend_i;
    assign w_dvs_mag  = w_dvs_neg ? (-divisor_i) : divisor_i;
    assign w_last     = (r_cnt == c_cnt_last);

    div_step #(
        .DATA_W (DATA_W)
    ) u_div_step (
        .rem_i     (r_rem),
        .quo_i     (r_quo),
        .divisor_i (r_dvs),
        .rem_o     (w_step_rem),
        .quo_o     (w_step_quo)
    );

    // Sign fix; the most-negative / -1 case wraps back to itself naturally.
    assign w_fix_q = r_neg_q ? (-w_step_quo) : w_step_quo;
    assign w_fix_r = r_neg_r ? (-w_step_rem) : w_step_rem;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DIV_IDLE: begin
                if (start_i && !annul_i) begin
                    w_state_nxt = w_dvs_zero ? DIV_DIVZERO : DIV_RUN;
                end
            end
            DIV_DIVZERO: w_state_nxt = DIV_DONE;
            DIV_RUN: begin
                if (w_last) begin
                    w_state_nxt = DIV_DONE;
                end
            end
            DIV_DONE: w_state_nxt = DIV_IDLE;
            default:  w_state_nxt = DIV_IDLE;
        endcase
        if (annul_i) begin
            w_state_nxt = DIV_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                DIV_IDLE: begin
                    if (w_accept) begin
                        // Divide-by-zero keeps the raw dividend for HI.
                        r_quo   <= w_dvs_zero ? dividend_i : w_dvd_mag;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_dvs   <= w_dvs_mag;
                        r_neg_q <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r <= w_dvd_neg;
                    end
                end
                DIV_RUN: begin
                    r_rem <= w_step_rem;
                    r_quo <= w_step_quo;
                    r_cnt <= r_cnt + 1'b1;
                    // Results land on entry to DONE so they are valid with ready_o.
                    if (w_last && !annul_i) begin
                        r_hi <= w_fix_r;
                        r_lo <= w_fix_q;
                    end
                end
                DIV_DIVZERO: begin
                    if (!annul_i) begin
                        r_hi <= r_quo;
                        r_lo <= '1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stall_o     = w_accept || (r_state == DIV_DIVZERO) || (r_state == DIV_RUN);
    assign ready_o     = (r_state == DIV_DONE);
    assign writeHILO_o = (r_state == DIV_DONE) ? HILO_BOTH : HILO_NONE;
    assign HI_data_o   = r_hi;
    assign LO_data_o   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_hilo_div_sequencer.sv
// ============================================================================
// Module      : tb_hilo_div_sequencer
// Description : Directed self-checking bench for hilo_div_sequencer
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hilo_div_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        annul_i;
    logic        stall_o;
    logic        ready_o;
    logic [1:0]  writeHILO_o;
    logic [31:0] HI_data_o;
    logic [31:0] LO_data_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hilo_div_sequencer #(
        .DATA_W (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .annul_i     (annul_i),
        .stall_o     (stall_o),
        .ready_o     (ready_o),
        .writeHILO_o (writeHILO_o),
        .HI_data_o   (HI_data_o),
        .LO_data_o   (LO_data_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start in the current cycle (T) and follow the full 33-cycle divide.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi);
        int stalls = 0;
        int readys = 0;
        start_i    = 1'b1;
        signed_i   = sgn;
        dividend_i = a;
        divisor_i  = b;
        #1;
        if (stall_o) stalls++;
        tick();
        start_i = 1'b0;
        repeat (32) begin
            if (stall_o) stalls++;
            if (ready_o) readys++;
            tick();
        end
        check_eq({tag, "_stall_cycles"}, stalls, 33);
        check_eq({tag, "_early_ready"}, readys, 0);
        check_eq({tag, "_stall_done"}, {31'd0, stall_o}, 32'd0);
        check_eq({tag, "_ready"}, {31'd0, ready_o}, 32'd1);
        check_eq({tag, "_whilo"}, {30'd0, writeHILO_o}, 32'd3);
        check_eq({tag, "_lo"}, LO_data_o, exp_lo);
        check_eq({tag, "_hi"}, HI_data_o, exp_hi);
        tick();
        check_eq({tag, "_ready_after"}, {31'd0, ready_o}, 32'd0);
        check_eq({tag, "_whilo_after"}, {30'd0, writeHILO_o}, 32'd0);
        check_eq({tag, "_lo_hold"}, LO_data_o, exp_lo);
    endtask

    task automatic run_dz(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        start_i    = 1'b1;
        signed_i   = sgn;
        dividend_i = a;
        divisor_i  = 32'd0;
        #1;
        check_eq({tag, "_stall_t0"}, {31'd0, stall_o}, 32'd1);
        tick();
        start_i = 1'b0;
        check_eq({tag, "_stall_t1"}, {31'd0, stall_o}, 32'd1);
        check_eq({tag, "_ready_t1"}, {31'd0, ready_o}, 32'd0);
        tick();
        check_eq({tag, "_stall_t2"}, {31'd0, stall_o}, 32'd0);
        check_eq({tag, "_ready_t2"}, {31'd0, ready_o}, 32'd1);
        check_eq({tag, "_whilo_t2"}, {30'd0, writeHILO_o}, 32'd3);
        check_eq({tag, "_lo"}, LO_data_o, exp_lo);
        check_eq({tag, "_hi"}, HI_data_o, exp_hi);
        tick();
        check_eq({tag, "_ready_t3"}, {31'd0, ready_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int readys;
        rst        = 1'b1;
        start_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = 32'd0;
        divisor_i  = 32'd0;
        annul_i    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_stall", {31'd0, stall_o}, 32'd0);
        check_eq("rst_ready", {31'd0, ready_o}, 32'd0);
        check_eq("rst_whilo", {30'd0, writeHILO_o}, 32'd0);
        check_eq("rst_hi", HI_data_o, 32'd0);
        check_eq("rst_lo", LO_data_o, 32'd0);

        run_div("divu_100_7",  1'b0, 32'd100,       32'd7,         32'd14,        32'd2);
        run_div("div_m7_2",    1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF);
        run_div("div_7_m2",    1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1);
        run_div("div_min_m1",  1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0);
        run_div("divu_max_1",  1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0);
        run_div("div_m100_m7", 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE);
        run_div("divu_big",    1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000);

        run_dz("dz_u", 1'b0, 32'h00001234, 32'hFFFFFFFF, 32'h00001234);
        run_dz("dz_s", 1'b1, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFFB);

        // Annul at T+10 of a running divide; restart at T+11.
        readys     = 0;
        start_i    = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd100;
        divisor_i  = 32'd7;
        tick();
        start_i = 1'b0;
        repeat (9) begin
            if (ready_o) readys++;
            tick();
        end
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0;
        #1;
        check_eq("annul_no_ready", readys, 0);
        check_eq("annul_stall", {31'd0, stall_o}, 32'd0);
        check_eq("annul_ready", {31'd0, ready_o}, 32'd0);
        check_eq("annul_whilo", {30'd0, writeHILO_o}, 32'd0);
        check_eq("annul_hi_keep", HI_data_o, 32'hFFFFFFFB);
        check_eq("annul_lo_keep", LO_data_o, 32'hFFFFFFFF);
        run_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

        // Reset at T+5 mid-RUN with start held into T+6.
        start_i    = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd20;
        divisor_i  = 32'd6;
        tick();
        start_i = 1'b0;
        repeat (4) tick();
        rst     = 1'b1;
        start_i = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("midrst_ready", {31'd0, ready_o}, 32'd0);
        check_eq("midrst_whilo", {30'd0, writeHILO_o}, 32'd0);
        check_eq("midrst_hi", HI_data_o, 32'd0);
        check_eq("midrst_lo", LO_data_o, 32'd0);
        check_eq("midrst_stall_start", {31'd0, stall_o}, 32'd1);
        run_div("midrst_20_6", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2);

        // Same-cycle start and annul in IDLE: nothing starts.
        start_i    = 1'b1;
        annul_i    = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd50;
        divisor_i  = 32'd5;
        #1;
        check_eq("sa_stall", {31'd0, stall_o}, 32'd0);
        tick();
        start_i = 1'b0;
        annul_i = 1'b0;
        #1;
        check_eq("sa_stall_next", {31'd0, stall_o}, 32'd0);
        check_eq("sa_ready_next", {31'd0, ready_o}, 32'd0);
        check_eq("sa_lo_keep", LO_data_o, 32'd3);
        run_div("sa_then_50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
